// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter.
// State encoding, sizing constants and one-hot encode.
package arb_pkg;

   localparam int N_REQ = 4;
   localparam int IDX_W = 2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   // Valid for one-hot or zero input; zero maps to index 0.
   function automatic logic [IDX_W-1:0] onehot_to_idx(
      input logic [N_REQ-1:0] oh
   );
      return {oh[3] | oh[2], oh[3] | oh[1]};
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotating-priority picker: first set mask bit scanning
// cyclically upward from ptr wins.
module rr_pick4
   import arb_pkg::*;
(
   input  logic [IDX_W-1:0] ptr,
   input  logic [N_REQ-1:0] mask,
   output logic [N_REQ-1:0] onehot,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   always_comb begin
      idx = '0;
      // Walk from lowest to highest priority so the
      // highest-priority hit is written last.
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (mask[IDX_W'(ptr + IDX_W'(k))]) begin
            idx = IDX_W'(ptr + IDX_W'(k));
         end
      end
      any    = |mask;
      onehot = any ? (N_REQ'(1) << idx) : '0;
   end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot
// grant, encoded index and optional per-owner hold limit.
module rr_arbiter4
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid
);

   localparam int HW =
      (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
   localparam logic [HW-1:0] ONE      = HW'(1);

   state_e           state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [HW-1:0]    hold_q, hold_d;

   logic [IDX_W-1:0] own;
   logic [IDX_W-1:0] pick_ptr;
   logic [N_REQ-1:0] pick_oh;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;
   logic             timeout;
   logic             stay;

   assign own     = onehot_to_idx(gnt_q);
   assign timeout = (MAX_HOLD != 0) && (hold_q == HOLD_MAX);
   assign stay    = req[own] && !timeout;

   // On release the scan starts just past the outgoing owner.
   assign pick_ptr =
      (state_q == GRANT) ? own + 2'd1 : ptr_q;

   rr_pick4 u_pick (
      .ptr    (pick_ptr),
      .mask   (req),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               gnt_d   = pick_oh;
               hold_d  = ONE;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (stay) begin
               if (hold_q != '1) hold_d = hold_q + ONE;
            end else begin
               ptr_d = own + 2'd1;
               if (pick_any) begin
                  gnt_d  = pick_oh;
                  hold_d = ONE;
               end else begin
                  gnt_d   = '0;
                  state_d = IDLE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         ptr_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_idx   = own;
   assign gnt_valid = |gnt_q;

   logic unused_idx;
   assign unused_idx = ^pick_idx;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Scoreboard bench for rr_arbiter4 at MAX_HOLD=8 and 4,
// plus directed checks of the key arbitration scenarios.
module tb_rr_arbiter4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req, req4;
   logic [3:0] gnt, gnt4;
   logic [1:0] idx, idx4;
   logic       v, v4;

   rr_arbiter4 #(.MAX_HOLD(8)) dut (
      .clk(clk), .rst(rst), .req(req),
      .gnt(gnt), .gnt_idx(idx), .gnt_valid(v)
   );

   rr_arbiter4 #(.MAX_HOLD(4)) dut4 (
      .clk(clk), .rst(rst), .req(req4),
      .gnt(gnt4), .gnt_idx(idx4), .gnt_valid(v4)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       act;
      logic [1:0] own;
      logic [1:0] ptr;
      int         hold;
   } m_t;

   m_t          m8, m4;
   logic [13:0] sb[$];
   int          owners[$];
   int          checks = 0;
   int          failures = 0;
   logic [3:0]  hist[20];

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] scan(
      input logic [1:0] p, input logic [3:0] r);
      for (int k = 0; k < 4; k++) begin
         int i;
         i = (int'(p) + k) % 4;
         if (r[i]) return 2'(i);
      end
      return 2'd0;
   endfunction

   function automatic m_t step(input m_t s,
                               input logic r_st,
                               input logic [3:0] r,
                               input int mh);
      m_t n;
      n = s;
      if (r_st) begin
         n.act = 1'b0; n.own = '0;
         n.ptr = '0;   n.hold = 0;
      end else if (!s.act) begin
         if (r != 0) begin
            n.act  = 1'b1;
            n.own  = scan(s.ptr, r);
            n.hold = 1;
         end
      end else if (r[s.own] && (mh == 0 || s.hold < mh)) begin
         n.hold = s.hold + 1;
      end else begin
         n.ptr = s.own + 2'd1;
         if (r != 0) begin
            n.own  = scan(n.ptr, r);
            n.hold = 1;
         end else begin
            n.act = 1'b0;
         end
      end
      return n;
   endfunction

   function automatic logic [6:0] outs(input m_t s);
      logic [3:0] g;
      g = 4'b0001 << s.own;
      return s.act ? {g, s.own, 1'b1} : 7'b0;
   endfunction

   task automatic cycle(input logic r_st,
                        input logic [3:0] r8,
                        input logic [3:0] r4v);
      logic [13:0] e;
      rst  = r_st;
      req  = r8;
      req4 = r4v;
      m8 = step(m8, r_st, r8, 8);
      m4 = step(m4, r_st, r4v, 4);
      sb.push_back({outs(m8), outs(m4)});
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         chk("sb_dut8", {gnt, idx, v}, e[13:7]);
         chk("sb_dut4", {gnt4, idx4, v4}, e[6:0]);
      end
   endtask

   initial begin
      m8 = '{act: 1'b0, own: 2'd0, ptr: 2'd0, hold: 0};
      m4 = m8;
      rst = 1'b1; req = '0; req4 = '0;

      // Reset then single request
      cycle(1'b1, 4'b0000, 4'b0000);
      cycle(1'b1, 4'b0000, 4'b0000);
      chk("reset_out", {gnt, idx, v}, 7'b0);
      cycle(1'b0, 4'b0100, 4'b1000);
      chk("first_gnt", {gnt, idx, v}, {4'b0100, 2'b10, 1'b1});
      chk("sole_first", {gnt4, idx4}, {4'b1000, 2'b11});
      cycle(1'b0, 4'b0000, 4'b1000);

      // Hold limit on dut8; sole-requester timeout on dut4
      cycle(1'b0, 4'b0000, 4'b1000);
      for (int c = 0; c < 20; c++) begin
         cycle(1'b0, 4'b0011, 4'b1000);
         hist[c] = gnt;
         chk("sole_hold", {gnt4, idx4, v4},
             {4'b1000, 2'b11, 1'b1});
      end
      for (int c = 0; c < 8; c++)
         chk("hold_own0", hist[c], 4'b0001);
      for (int c = 8; c < 16; c++)
         chk("hold_own1", hist[c], 4'b0010);
      chk("hold_back0", hist[16], 4'b0001);

      // Release to idle and pointer wrap
      cycle(1'b0, 4'b0000, 4'b0000);
      cycle(1'b0, 4'b0010, 4'b0000);
      chk("gnt_to_1", gnt, 4'b0010);
      cycle(1'b0, 4'b0000, 4'b0000);
      chk("idle_out", {gnt, idx, v}, 7'b0);
      cycle(1'b0, 4'b0000, 4'b0000);
      cycle(1'b0, 4'b0011, 4'b0000);
      chk("ptr_wrap", gnt, 4'b0001);

      // Fairness with all requesting
      cycle(1'b1, 4'b0000, 4'b0000);
      owners.delete();
      for (int c = 0; c < 20; c++) begin
         logic [3:0] r;
         r = 4'b1111;
         if (m8.act && m8.hold >= 2) r[m8.own] = 1'b0;
         cycle(1'b0, r, 4'b1111);
         chk("fair_nogap", {31'd0, v}, 32'd1);
         if (owners.size() == 0 ||
             owners[owners.size() - 1] != int'(idx))
            owners.push_back(int'(idx));
      end
      if (owners.size() < 5) begin
         chk("fair_len", owners.size(), 5);
      end else begin
         for (int i = 0; i < 5; i++)
            chk("fair_seq", owners[i], i % 4);
      end

      // Reset mid-grant
      cycle(1'b1, 4'b0000, 4'b0000);
      cycle(1'b0, 4'b0100, 4'b0000);
      cycle(1'b0, 4'b0100, 4'b0000);
      chk("mid_own2", gnt, 4'b0100);
      cycle(1'b1, 4'b0101, 4'b0101);
      chk("mid_rst", {gnt, idx, v}, 7'b0);
      cycle(1'b0, 4'b0101, 4'b0101);
      chk("rst_ptr0", gnt, 4'b0001);
      chk("rst_ptr0_4", gnt4, 4'b0001);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
